branch_module_multi: RTL and testbench
======================================

BRANCH_MODULE_MULTI -- requirements
Module: branch_module_multi

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 36: config data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: config address width.
REQ-003 SHALL have parameter PC_WIDTH, default 10: program counter width.
REQ-004 SHALL have parameter COUNT_WIDTH, default 16: loop counter width, which SHALL be no greater than WORD_WIDTH.
REQ-005 SHALL have parameter BRANCH_COUNT, default 4: number of branch channels, 1..16.
REQ-006 SHALL have parameter THREAD_COUNT, default 8, with THREAD_COUNT_WIDTH, default 3: number of barrel threads.
REQ-007 SHALL have parameter CONFIG_ADDR_BASE, default 0: first config word address.
REQ-008 SHALL have ports: clock in 1, the single clock; clear in 1, the reset, which is synchronous and active-high.
REQ-009 SHALL have ports: PC in PC_WIDTH, the current thread's PC; A_negative, A_carryout, A_external, B_lessthan, B_external in 1, the condition flags.
REQ-010 SHALL have ports: config_wren in 1; config_addr in ADDR_WIDTH; config_data in WORD_WIDTH.
REQ-011 SHALL have ports: jump out 1; destination out PC_WIDTH; cancel out 1; thread out THREAD_COUNT_WIDTH, the thread the outputs belong to.

Function
REQ-012 SHALL keep an internal thread counter that is 0 after clear, advances by 1 every cycle, and wraps from THREAD_COUNT-1 to 0.
REQ-013 SHALL give each channel c a 4-word config block at CONFIG_ADDR_BASE+4c+k, where k=0 is origin PC, k=1 is destination PC, k=2 is control, and k=3 is count reload.
- Origin and destination take config_data[PC_WIDTH-1:0].
- Count reload takes config_data[COUNT_WIDTH-1:0].
REQ-014 SHALL decode the control word as follows:
- bits[2:0] select: 0 never, 1 always, 2 A_negative, 3 A_carryout, 4 B_lessthan, 5 A_external, 6 B_external, 7 counter.
- bit3: cancel-enable.
- bit4: channel enable.
REQ-015 SHALL ignore config writes outside CONFIG_ADDR_BASE..CONFIG_ADDR_BASE+4*BRANCH_COUNT-1, with no state change.
REQ-016 SHALL keep one COUNT_WIDTH counter per (channel, thread); a write to k=3 SHALL load the reload value into the counters of that channel for all threads.
REQ-017 SHALL treat channel c as matching when it is enabled and PC equals origin[c].
- A matching channel is taken when its selected condition is true.
- For select 7, taken is counter[c][thread] != 0.
REQ-018 SHALL update the select-7 counter of a matching channel as follows:
- When taken, the counter SHALL decrement by 1.
- When not taken (counter is 0), it SHALL reload to the reload value, giving reload+1 executions of the loop body per entry.
- A counter SHALL change only for the current thread and only on a match.
REQ-019 SHALL resolve priority so that, among taken channels, the lowest index wins; counters of all matching select-7 channels SHALL update regardless of which channel wins.
REQ-020 SHALL register the outputs with a latency of one cycle, using the inputs of cycle N:
- In cycle N+1, jump = any channel taken.
- destination = destination[winner], or 0 when no channel is taken.
- cancel = jump AND cancel-enable[winner].
- thread = the thread number of cycle N.
REQ-021 SHALL resolve a config write to channel c that coincides with a match on c as follows:
- The match SHALL use the pre-write config.
- A k=3 write SHALL override any decrement or reload in the same cycle.
REQ-022 SHALL make config writes visible to the matching logic from the next cycle.

Reset
REQ-023 SHALL, while clear is high, set the following on the next edge:
- jump=0, destination=0, cancel=0, thread=0, thread counter=0.
- All control words=0, so every channel is disabled.
- All counters, origins, destinations and reloads=0.
REQ-024 SHALL ignore config writes while clear is asserted, and SHALL apply a clear arriving mid-loop immediately, discarding counter state.

Verification
REQ-025 SHALL pass this scenario: channel 0 configured with origin 0x10, destination 0x20, control 0x11 (always, enabled), no cancel; PC=0x10 in cycle N -> jump=1, destination=0x20, cancel=0 in N+1.
REQ-026 SHALL pass this scenario: channel 1 configured with select 7 and reload 2; thread 3 hits the origin on 4 successive passes -> taken, taken, not-taken with counter reloaded, then taken; other threads' counters stay at 2.
REQ-027 SHALL pass this scenario: channels 0 and 2 both match, with channel 0 selecting A_negative=0 and channel 2 always with cancel -> channel 2 wins and cancel=1; with A_negative=1, channel 0 wins and destination=destination[0].
REQ-028 SHALL pass this scenario: a write to CONFIG_ADDR_BASE+4*BRANCH_COUNT -> no channel state changes.
REQ-029 SHALL pass this scenario: a k=3 write in the same cycle as a select-7 match on that channel -> the counter equals the new reload value and the jump uses the old state.
REQ-030 SHALL pass this scenario: clear asserted during a loop -> outputs are 0 next cycle, thread restarts at 0, and no jump occurs until reconfigured.

Source files
------------

// File: rtl/branch_module_multi.sv
// Multi-channel branch unit for a barrel-threaded core: per-channel origin/destination
// matching, flag or per-thread loop-counter conditions, lowest-index priority.
module branch_module_multi #(
  parameter int unsigned WORD_WIDTH         = 36,
  parameter int unsigned ADDR_WIDTH         = 10,
  parameter int unsigned PC_WIDTH           = 10,
  parameter int unsigned COUNT_WIDTH        = 16,
  parameter int unsigned BRANCH_COUNT       = 4,
  parameter int unsigned THREAD_COUNT       = 8,
  parameter int unsigned THREAD_COUNT_WIDTH = 3,
  parameter int unsigned CONFIG_ADDR_BASE   = 0
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic [PC_WIDTH-1:0]           PC,
  input  logic                          A_negative,
  input  logic                          A_carryout,
  input  logic                          A_external,
  input  logic                          B_lessthan,
  input  logic                          B_external,
  input  logic                          config_wren,
  input  logic [ADDR_WIDTH-1:0]         config_addr,
  input  logic [WORD_WIDTH-1:0]         config_data,
  output logic                          jump,
  output logic [PC_WIDTH-1:0]           destination,
  output logic                          cancel,
  output logic [THREAD_COUNT_WIDTH-1:0] thread
);

  localparam int unsigned CTRL_WIDTH = 5;
  localparam int unsigned CFG_WORDS  = 4 * BRANCH_COUNT;
  localparam int unsigned CH_WIDTH   = (BRANCH_COUNT > 1) ? $clog2(BRANCH_COUNT) : 1;

  typedef enum logic [2:0] {
    SEL_NEVER   = 3'd0,
    SEL_ALWAYS  = 3'd1,
    SEL_A_NEG   = 3'd2,
    SEL_A_CARRY = 3'd3,
    SEL_B_LT    = 3'd4,
    SEL_A_EXT   = 3'd5,
    SEL_B_EXT   = 3'd6,
    SEL_COUNT   = 3'd7
  } sel_e;

  logic [PC_WIDTH-1:0]           origin_q [BRANCH_COUNT];
  logic [PC_WIDTH-1:0]           dest_q   [BRANCH_COUNT];
  logic [CTRL_WIDTH-1:0]         ctrl_q   [BRANCH_COUNT];
  logic [COUNT_WIDTH-1:0]        reload_q [BRANCH_COUNT];
  logic [COUNT_WIDTH-1:0]        count_q  [BRANCH_COUNT][THREAD_COUNT];
  logic [THREAD_COUNT_WIDTH-1:0] thr_q;

  logic [31:0]             cfg_offset_c;
  logic                    cfg_hit_c;
  logic [CH_WIDTH-1:0]     cfg_ch_c;
  logic [1:0]              cfg_k_c;
  logic [BRANCH_COUNT-1:0] match_c;
  logic [BRANCH_COUNT-1:0] cond_c;
  logic [BRANCH_COUNT-1:0] taken_c;
  logic [BRANCH_COUNT-1:0] is_loop_c;
  logic                    any_taken_c;
  logic [PC_WIDTH-1:0]     win_dest_c;
  logic                    win_cancel_c;
  logic                    cfg_data_unused;

  // Only the low bits of a config word carry information.
  assign cfg_data_unused = ^config_data;

  // Config address decode: window check, channel and word-within-block.
  always_comb begin
    cfg_offset_c = 32'(config_addr) - 32'(CONFIG_ADDR_BASE);
    cfg_hit_c    = config_wren && (32'(config_addr) >= 32'(CONFIG_ADDR_BASE))
                   && (cfg_offset_c < 32'(CFG_WORDS));
    cfg_k_c      = cfg_offset_c[1:0];
    cfg_ch_c     = CH_WIDTH'(cfg_offset_c >> 2);
  end

  // Per-channel match and condition evaluation for the current thread.
  always_comb begin
    match_c   = '0;
    cond_c    = '0;
    taken_c   = '0;
    is_loop_c = '0;
    for (int c = 0; c < int'(BRANCH_COUNT); c++) begin
      match_c[c]   = ctrl_q[c][4] && (PC == origin_q[c]);
      is_loop_c[c] = (sel_e'(ctrl_q[c][2:0]) == SEL_COUNT);
      case (sel_e'(ctrl_q[c][2:0]))
        SEL_NEVER:   cond_c[c] = 1'b0;
        SEL_ALWAYS:  cond_c[c] = 1'b1;
        SEL_A_NEG:   cond_c[c] = A_negative;
        SEL_A_CARRY: cond_c[c] = A_carryout;
        SEL_B_LT:    cond_c[c] = B_lessthan;
        SEL_A_EXT:   cond_c[c] = A_external;
        SEL_B_EXT:   cond_c[c] = B_external;
        default:     cond_c[c] = |count_q[c][thr_q];
      endcase
      taken_c[c] = match_c[c] && cond_c[c];
    end
  end

  // Lowest-index taken channel wins; scanning downwards leaves it last-assigned.
  always_comb begin
    any_taken_c  = |taken_c;
    win_dest_c   = '0;
    win_cancel_c = 1'b0;
    for (int c = int'(BRANCH_COUNT) - 1; c >= 0; c--) begin
      if (taken_c[c]) begin
        win_dest_c   = dest_q[c];
        win_cancel_c = ctrl_q[c][3];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      thr_q       <= '0;
      jump        <= 1'b0;
      destination <= '0;
      cancel      <= 1'b0;
      thread      <= '0;
      for (int c = 0; c < int'(BRANCH_COUNT); c++) begin
        origin_q[c] <= '0;
        dest_q[c]   <= '0;
        ctrl_q[c]   <= '0;
        reload_q[c] <= '0;
        for (int t = 0; t < int'(THREAD_COUNT); t++) count_q[c][t] <= '0;
      end
    end else begin
      thr_q       <= (thr_q == THREAD_COUNT_WIDTH'(THREAD_COUNT - 1)) ? '0
                     : thr_q + THREAD_COUNT_WIDTH'(1);
      jump        <= any_taken_c;
      destination <= win_dest_c;
      cancel      <= any_taken_c && win_cancel_c;
      thread      <= thr_q;
      // Loop counters: decrement while iterating, reload on loop exit.
      for (int c = 0; c < int'(BRANCH_COUNT); c++) begin
        if (match_c[c] && is_loop_c[c]) begin
          count_q[c][thr_q] <= taken_c[c] ? count_q[c][thr_q] - COUNT_WIDTH'(1)
                                          : reload_q[c];
        end
      end
      // Config writes come last so a reload write overrides the loop update.
      if (cfg_hit_c) begin
        case (cfg_k_c)
          2'd0: origin_q[cfg_ch_c] <= config_data[PC_WIDTH-1:0];
          2'd1: dest_q[cfg_ch_c]   <= config_data[PC_WIDTH-1:0];
          2'd2: ctrl_q[cfg_ch_c]   <= config_data[CTRL_WIDTH-1:0];
          default: begin
            reload_q[cfg_ch_c] <= config_data[COUNT_WIDTH-1:0];
            for (int t = 0; t < int'(THREAD_COUNT); t++)
              count_q[cfg_ch_c][t] <= config_data[COUNT_WIDTH-1:0];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_module_multi.sv
// Directed self-checking bench for branch_module_multi (default parameters).
module tb_branch_module_multi;

  localparam logic [9:0] IDLE = 10'h3FF;

  logic        clock = 1'b0;
  logic        clear;
  logic [9:0]  PC;
  logic        A_negative, A_carryout, A_external, B_lessthan, B_external;
  logic        config_wren;
  logic [9:0]  config_addr;
  logic [35:0] config_data;
  logic        jump;
  logic [9:0]  destination;
  logic        cancel;
  logic [2:0]  thread;

  int checks   = 0;
  int failures = 0;
  int tcur     = 0;

  always #5 clock = ~clock;

  branch_module_multi dut (
    .clock       (clock),
    .clear       (clear),
    .PC          (PC),
    .A_negative  (A_negative),
    .A_carryout  (A_carryout),
    .A_external  (A_external),
    .B_lessthan  (B_lessthan),
    .B_external  (B_external),
    .config_wren (config_wren),
    .config_addr (config_addr),
    .config_data (config_data),
    .jump        (jump),
    .destination (destination),
    .cancel      (cancel),
    .thread      (thread)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: apply PC, then check the registered outputs for that cycle.
  task automatic run(input logic [9:0] pc, input logic ej, input logic [9:0] ed,
                     input logic ec, input string tag);
    int et;
    PC = pc;
    et = clear ? 0 : tcur;
    @(posedge clock);
    #1;
    chk({tag, ".jump"},   64'(jump),        64'(ej));
    chk({tag, ".dest"},   64'(destination), 64'(ed));
    chk({tag, ".cancel"}, 64'(cancel),      64'(ec));
    chk({tag, ".thread"}, 64'(thread),      64'(et));
    tcur = clear ? 0 : (tcur + 1) % 8;
    config_wren = 1'b0;
  endtask

  task automatic idle();
    run(IDLE, 1'b0, 10'h0, 1'b0, "idle");
  endtask

  task automatic wcfg(input logic [9:0] a, input logic [35:0] d);
    config_wren = 1'b1;
    config_addr = a;
    config_data = d;
    run(IDLE, 1'b0, 10'h0, 1'b0, "cfg");
  endtask

  task automatic wait_thread(input int t);
    while (tcur != t) idle();
  endtask

  // Bit order: A_negative, A_carryout, B_lessthan, A_external, B_external (selects 2..6).
  task automatic set_flags(input logic [4:0] f);
    A_negative = f[0];
    A_carryout = f[1];
    B_lessthan = f[2];
    A_external = f[3];
    B_external = f[4];
  endtask

  initial begin
    logic [9:0] pcs [5];
    pcs = '{10'h30, 10'h50, 10'h80, 10'h10, 10'h00};
    clear = 1'b1;
    config_wren = 1'b0;
    config_addr = '0;
    config_data = '0;
    set_flags(5'b0);
    run(IDLE, 1'b0, 10'h0, 1'b0, "reset");
    clear = 1'b0;

    // Single always-taken channel.
    wcfg(10'd0, 36'h10);
    wcfg(10'd1, 36'h20);
    wcfg(10'd2, 36'h11);
    run(10'h10, 1'b1, 10'h20, 1'b0, "always");

    // Loop channel 1, reload 2: thread 3 sees taken, taken, exit, taken.
    wcfg(10'd4, 36'h30);
    wcfg(10'd5, 36'h40);
    wcfg(10'd6, 36'h17);
    wcfg(10'd7, 36'h2);
    wait_thread(3); run(10'h30, 1'b1, 10'h40, 1'b0, "loop_t3_p1");
    wait_thread(3); run(10'h30, 1'b1, 10'h40, 1'b0, "loop_t3_p2");
    wait_thread(3); run(10'h30, 1'b0, 10'h00, 1'b0, "loop_t3_p3");
    wait_thread(3); run(10'h30, 1'b1, 10'h40, 1'b0, "loop_t3_p4");
    // Thread 5 still holds the original reload of 2.
    wait_thread(5); run(10'h30, 1'b1, 10'h40, 1'b0, "loop_t5_p1");
    wait_thread(5); run(10'h30, 1'b1, 10'h40, 1'b0, "loop_t5_p2");
    wait_thread(5); run(10'h30, 1'b0, 10'h00, 1'b0, "loop_t5_p3");

    // Priority: ch0 on A_negative, ch2 always with cancel, same origin.
    wcfg(10'd0, 36'h50);
    wcfg(10'd1, 36'h60);
    wcfg(10'd2, 36'h12);
    wcfg(10'd8, 36'h50);
    wcfg(10'd9, 36'h70);
    wcfg(10'd10, 36'h19);
    A_negative = 1'b0;
    run(10'h50, 1'b1, 10'h70, 1'b1, "prio_ch2");
    A_negative = 1'b1;
    run(10'h50, 1'b1, 10'h60, 1'b0, "prio_ch0");
    A_negative = 1'b0;

    // Each flag select on channel 3.
    wcfg(10'd12, 36'h80);
    wcfg(10'd13, 36'h90);
    for (int s = 2; s <= 6; s++) begin
      wcfg(10'd14, 36'(32'h10 | 32'(s)));
      set_flags(5'(1 << (s - 2)));
      run(10'h80, 1'b1, 10'h90, 1'b0, "sel_on");
      set_flags(~5'(1 << (s - 2)));
      run(10'h80, 1'b0, 10'h00, 1'b0, "sel_off");
    end
    wcfg(10'd14, 36'h10);
    set_flags(5'h1F);
    run(10'h80, 1'b0, 10'h00, 1'b0, "sel_never");
    set_flags(5'h00);
    wcfg(10'd14, 36'h11);
    run(10'h80, 1'b1, 10'h90, 1'b0, "sel_always");
    wcfg(10'd14, 36'h01);
    run(10'h80, 1'b0, 10'h00, 1'b0, "disabled");

    // Writes just past the config window must not alias onto channel 0.
    for (int a = 16; a < 20; a++) wcfg(10'(a), 36'h0);
    A_negative = 1'b1;
    run(10'h50, 1'b1, 10'h60, 1'b0, "oob_write");

    // Control write coinciding with a match uses the old control word.
    config_wren = 1'b1; config_addr = 10'd2; config_data = 36'h0;
    run(10'h50, 1'b1, 10'h60, 1'b0, "pre_write");
    run(10'h50, 1'b1, 10'h70, 1'b1, "post_write");
    A_negative = 1'b0;

    // Reload write coinciding with a loop match: old state decides, new reload wins.
    wcfg(10'd7, 36'h0);
    wait_thread(2);
    config_wren = 1'b1; config_addr = 10'd7; config_data = 36'h3;
    run(10'h30, 1'b0, 10'h00, 1'b0, "k3_same");
    wait_thread(2); run(10'h30, 1'b1, 10'h40, 1'b0, "k3_p1");
    wait_thread(2); run(10'h30, 1'b1, 10'h40, 1'b0, "k3_p2");
    wait_thread(2); run(10'h30, 1'b1, 10'h40, 1'b0, "k3_p3");
    wait_thread(2); run(10'h30, 1'b0, 10'h00, 1'b0, "k3_p4");
    wait_thread(4); run(10'h30, 1'b1, 10'h40, 1'b0, "k3_t4");

    // Clear mid-loop, with a config write that must be ignored.
    wcfg(10'd7, 36'h5);
    wait_thread(1); run(10'h30, 1'b1, 10'h40, 1'b0, "loop_pre_clear");
    clear = 1'b1;
    config_wren = 1'b1; config_addr = 10'd2; config_data = 36'h11;
    run(10'h30, 1'b0, 10'h00, 1'b0, "clear");
    clear = 1'b0;
    for (int i = 0; i < 16; i++) run(pcs[i % 5], 1'b0, 10'h00, 1'b0, "post_clear");
    wcfg(10'd1, 36'h55);
    wcfg(10'd2, 36'h11);
    run(10'h00, 1'b1, 10'h55, 1'b0, "reconfig");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
